int_service_seq: RTL and testbench
==================================

Name: int_service_seq

Overview:
- CPU-side counterpart of the interrupt controller.
- Generates the machine-cycle strobe and consumes the 3-bit priority-resolved vector at instruction boundaries.
- On accepting a vector, stalls the core, pushes the return PC onto the stack (low byte first) and loads the PC with the vector address.
- Reports not-accepted and RETI-complete events back to the controller.

Parameters:
- CLK_PER_CM, 12, clocks per machine cycle; range 2..255.
- MAX_DEPTH, 2, maximum interrupt nesting levels.
- ACK_TIMEOUT, 64, clocks to wait for isq_stk_ack_i. Used only with ISQ_ACK_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge
- isq_rst_async_b_i  in  1  reset, asynchronous, active-low
- isq_vect_i  in  3  vector from controller: 0=EX0 … 6=TXRX, 7=no request
- isq_instr_end_i  in  1  core is at its last cycle of an instruction
- isq_blk_i  in  1  current instruction is RETI or a write to IE/IP
- isq_reti_i  in  1  one-cycle pulse, RETI executed
- isq_pc_i  in  16  return address (PC of next instruction)
- isq_stk_ack_i  in  1  stack write accepted
- isq_stk_req_o  out  1  stack write request
- isq_stk_data_o  out  8  byte to push
- isq_pc_load_o  out  1  one-cycle PC load strobe
- isq_pc_o  out  16  vector address
- isq_hold_o  out  1  stall core
- isq_cm_o  out  1  machine-cycle strobe, to controller int_cm_i
- isq_na_o  out  1  not-accepted pulse, to controller int_na_i
- isq_rdy_o  out  1  service-done pulse, to controller int_rdy_i
- isq_depth_o  out  2  current nesting depth
- isq_err_o  out  1  sticky stack timeout (0 unless ISQ_ACK_TIMEOUT_EN is defined)

Behaviour:
- Reset:
  - All outputs 0.
  - cm counter = 0, FSM = IDLE, depth = 0.
  - Reset is asynchronous and may assert in any state. The FSM aborts immediately and no partial PC load occurs.
- cm counter:
  - Free-running from 0 to CLK_PER_CM-1, then wraps to 0.
  - isq_cm_o = 1 for exactly the one cycle where count == CLK_PER_CM-1.
- Sample condition: isq_cm_o & isq_instr_end_i & (isq_vect_i != 7) & state == IDLE.
  - If isq_blk_i = 1: pulse isq_na_o for 1 cycle on the next clock and stay in IDLE.
  - If depth == MAX_DEPTH: pulse isq_na_o likewise and stay in IDLE.
  - Otherwise: latch isq_vect_i and isq_pc_i, set isq_hold_o = 1, go to PUSH_L.
- FSM:
  - IDLE: behaves as the sample condition above.
  - PUSH_L: isq_stk_req_o = 1, isq_stk_data_o = PC[7:0]. Stays until isq_stk_ack_i is sampled 1, then goes to PUSH_H.
  - PUSH_H: isq_stk_req_o = 1, isq_stk_data_o = PC[15:8]. On ack, goes to LOAD.
  - LOAD: isq_pc_load_o = 1, isq_pc_o = {10'b0, vect, 3'b011}, i.e. 8·vect + 3. Depth increments. Returns to IDLE.
  - isq_hold_o drops in the first IDLE cycle after LOAD.
  - isq_stk_req_o deasserts in the cycle after ack is sampled, then reasserts for the next byte. A 1-cycle ack gives 2 clocks per push.
  - Minimum latency from sample to PC load is 5 clocks.
- RETI handling:
  - isq_reti_i with depth > 0: isq_rdy_o pulses 1 cycle on the next clock and depth decrements.
  - isq_reti_i with depth == 0: ignored, no rdy pulse.
  - Increment and decrement in the same cycle leave depth unchanged.
- isq_vect_i is ignored outside the sample condition. Vector changes during PUSH/LOAD have no effect because the vector is latched.
- isq_na_o and isq_pc_load_o never assert in the same cycle.

Optional Feature:
- Macro: ISQ_ACK_TIMEOUT_EN.
- Defined:
  - A counter runs while in PUSH_L or PUSH_H, cleared on each ack.
  - On reaching ACK_TIMEOUT: isq_err_o is set (sticky until reset), the FSM returns to IDLE, hold is released, no PC load occurs and depth is unchanged.
- Undefined:
  - No counter; the FSM waits indefinitely for ack.
  - isq_err_o is tied to 0.

Test Plan:
- Reset, then run 30 clocks with CLK_PER_CM=12 -> isq_cm_o high at clocks 11 and 23 only; all other outputs stay 0.
- Vect=1, pc=0x1234, instr_end at a cm cycle, ack returned 1 cycle after each req -> pushes 0x34 then 0x12. Then pc_load with isq_pc_o=0x000B, depth=1, hold high throughout.
- Vect=2 with isq_blk_i=1 at the sample point -> isq_na_o single pulse, no stack req, hold=0.
- Accept twice (depth=2), then a third request vect=0 -> isq_na_o pulse. Then two isq_reti_i pulses -> two isq_rdy_o pulses and depth=0. A third reti -> no rdy pulse.
- Reset asserted mid PUSH_H -> req, hold and pc_load all immediately 0. After release, state is IDLE and depth=0.
- With ISQ_ACK_TIMEOUT_EN defined and ack withheld for 64 clocks in PUSH_L -> isq_err_o=1, hold=0, no pc_load, depth unchanged.

Source files
------------

// File: rtl/int_service_seq.sv
// int_service_seq: CPU-side interrupt service sequencer. Machine-cycle strobe, vector accept,
// return-PC push and vector load. Optional stack-ack watchdog: define ISQ_ACK_TIMEOUT_EN.
module int_service_seq #(
  parameter int CLK_PER_CM  = 12,
  parameter int MAX_DEPTH   = 2,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        isq_rst_async_b_i,
  input  logic [2:0]  isq_vect_i,
  input  logic        isq_instr_end_i,
  input  logic        isq_blk_i,
  input  logic        isq_reti_i,
  input  logic [15:0] isq_pc_i,
  input  logic        isq_stk_ack_i,
  output logic        isq_stk_req_o,
  output logic [7:0]  isq_stk_data_o,
  output logic        isq_pc_load_o,
  output logic [15:0] isq_pc_o,
  output logic        isq_hold_o,
  output logic        isq_cm_o,
  output logic        isq_na_o,
  output logic        isq_rdy_o,
  output logic [1:0]  isq_depth_o,
  output logic        isq_err_o
);
  localparam int            CW      = $clog2(CLK_PER_CM);
  localparam logic [CW-1:0] CM_LAST = CW'(CLK_PER_CM - 1);
  localparam logic [2:0]    NO_REQ  = 3'd7;

  typedef struct packed {
    logic [2:0]  vect;
    logic [15:0] pc;
  } svc_req_t;

  // GAP_* states give the one-cycle request drop between the two pushes and before the load
  typedef enum logic [2:0] {IDLE, PUSH_L, GAP_L, PUSH_H, GAP_H, LOAD} state_t;

  logic [CW-1:0] cm_cnt;
  state_t        state;
  svc_req_t      req_q;
  logic [1:0]    depth;
  logic          cm, sample, full, inc, dec, tmo;

  always_ff @(posedge clk or negedge isq_rst_async_b_i) begin
    if (!isq_rst_async_b_i) cm_cnt <= '0;
    else                    cm_cnt <= (cm_cnt == CM_LAST) ? '0 : cm_cnt + CW'(1);
  end

  assign cm       = (cm_cnt == CM_LAST);
  assign isq_cm_o = cm;
  assign sample   = cm & isq_instr_end_i & (isq_vect_i != NO_REQ) & (state == IDLE);
  assign full     = (depth >= 2'(MAX_DEPTH));
  assign inc      = (state == GAP_H);
  assign dec      = isq_reti_i & (depth != 2'd0);

`ifdef ISQ_ACK_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
  logic          pushing, err_q;

  assign pushing = (state == PUSH_L) || (state == PUSH_H);
  // ack on the final count still wins over the timeout
  assign tmo     = pushing & ~isq_stk_ack_i & (tmo_cnt == TW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge isq_rst_async_b_i) begin
    if (!isq_rst_async_b_i) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      tmo_cnt <= (!pushing || isq_stk_ack_i) ? '0 : tmo_cnt + TW'(1);
      err_q   <= err_q | tmo;
    end
  end

  assign isq_err_o = err_q;
`else
  assign tmo       = 1'b0;
  assign isq_err_o = (ACK_TIMEOUT < 0);
`endif

  always_ff @(posedge clk or negedge isq_rst_async_b_i) begin
    if (!isq_rst_async_b_i) begin
      state          <= IDLE;
      req_q          <= '0;
      isq_stk_req_o  <= 1'b0;
      isq_stk_data_o <= '0;
      isq_pc_load_o  <= 1'b0;
      isq_pc_o       <= '0;
      isq_hold_o     <= 1'b0;
      isq_na_o       <= 1'b0;
    end else begin
      isq_na_o      <= 1'b0;
      isq_pc_load_o <= 1'b0;
      case (state)
        IDLE: begin
          if (sample) begin
            if (isq_blk_i || full) begin
              isq_na_o <= 1'b1;
            end else begin
              req_q          <= '{vect: isq_vect_i, pc: isq_pc_i};
              isq_hold_o     <= 1'b1;
              isq_stk_req_o  <= 1'b1;
              isq_stk_data_o <= isq_pc_i[7:0];
              state          <= PUSH_L;
            end
          end
        end
        PUSH_L: begin
          if (tmo) begin
            isq_stk_req_o <= 1'b0;
            isq_hold_o    <= 1'b0;
            state         <= IDLE;
          end else if (isq_stk_ack_i) begin
            isq_stk_req_o <= 1'b0;
            state         <= GAP_L;
          end
        end
        GAP_L: begin
          isq_stk_req_o  <= 1'b1;
          isq_stk_data_o <= req_q.pc[15:8];
          state          <= PUSH_H;
        end
        PUSH_H: begin
          if (tmo) begin
            isq_stk_req_o <= 1'b0;
            isq_hold_o    <= 1'b0;
            state         <= IDLE;
          end else if (isq_stk_ack_i) begin
            isq_stk_req_o <= 1'b0;
            state         <= GAP_H;
          end
        end
        GAP_H: begin
          isq_pc_load_o <= 1'b1;
          isq_pc_o      <= {10'b0, req_q.vect, 3'b011};
          state         <= LOAD;
        end
        LOAD: begin
          isq_hold_o <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          isq_stk_req_o <= 1'b0;
          isq_hold_o    <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

  // depth is raised as the load strobe issues, so it reads the new level during LOAD
  always_ff @(posedge clk or negedge isq_rst_async_b_i) begin
    if (!isq_rst_async_b_i) begin
      depth     <= 2'd0;
      isq_rdy_o <= 1'b0;
    end else begin
      depth     <= depth + {1'b0, inc} - {1'b0, dec};
      isq_rdy_o <= dec;
    end
  end

  assign isq_depth_o = depth;

endmodule

// File: tb/tb_int_service_seq.sv
// Self-checking bench for int_service_seq: randomized service/RETI traffic against a
// transaction-level model (nesting depth, expected pushes, vector address, latency).
module tb_int_service_seq;
  localparam int CPM  = 12;
  localparam int MAXD = 2;
  localparam int TMO  = 64;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [2:0]  vect = 3'd7;
  logic        instr_end = 1'b0, blk = 1'b0, reti = 1'b0, ack = 1'b0;
  logic [15:0] pc_in = '0;
  logic        stk_req, pc_load, hold, cm, na, rdy, err;
  logic [7:0]  stk_data;
  logic [15:0] pc_out;
  logic [1:0]  depth;

  int n_tests = 0, n_fail = 0;
  int m_depth = 0;

  // ack responder controls and logs
  bit  ack_en = 1'b1;
  int  ack_budget = -1;
  int  ack_wait = 0, cur_dly = 0;
  logic [7:0] pushed[$];
  int  dlys[$];

  always #5 clk = ~clk;

  int_service_seq #(.CLK_PER_CM(CPM), .MAX_DEPTH(MAXD), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .isq_rst_async_b_i(rst_n), .isq_vect_i(vect), .isq_instr_end_i(instr_end),
    .isq_blk_i(blk), .isq_reti_i(reti), .isq_pc_i(pc_in), .isq_stk_ack_i(ack),
    .isq_stk_req_o(stk_req), .isq_stk_data_o(stk_data), .isq_pc_load_o(pc_load),
    .isq_pc_o(pc_out), .isq_hold_o(hold), .isq_cm_o(cm), .isq_na_o(na), .isq_rdy_o(rdy),
    .isq_depth_o(depth), .isq_err_o(err));

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ack = 1'b0; ack_wait = 0;
      end else if (ack) begin
        ack = 1'b0;
      end else if (ack_en && stk_req && ack_budget != 0) begin
        if (ack_wait >= cur_dly) begin
          ack = 1'b1;
          pushed.push_back(stk_data);
          dlys.push_back(cur_dly);
          ack_wait = 0;
          cur_dly = $urandom_range(0, 3);
          if (ack_budget > 0) ack_budget--;
        end else begin
          ack_wait++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_cm(input string nm);
    for (int k = 0; k < 2*CPM && !cm; k++) @(negedge clk);
    n_tests++;
    if (cm !== 1'b1) begin n_fail++; $display("FAIL %s_cm_wait: cm=%b want 1", nm, cm); end
  endtask

  task automatic test_reset;
    logic [30:0] outs;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    outs = {stk_req, stk_data, pc_load, pc_out, hold, cm, na, rdy, depth, err};
    n_tests++;
    if (outs !== '0) begin n_fail++; $display("FAIL reset_outs: got %h want 0", outs); end
    rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      n_tests++;
      if (cm !== ((k % CPM) == CPM-1)) begin
        n_fail++; $display("FAIL reset_cm_clk%0d: got %b want %b", k, cm, (k % CPM) == CPM-1);
      end
      outs = {stk_req, stk_data, pc_load, pc_out, hold, 1'b0, na, rdy, depth, err};
      if (outs !== '0) begin n_fail++; $display("FAIL reset_idle_clk%0d: got %h want 0", k, outs); end
    end
  endtask

  task automatic service(input logic [2:0] v, input logic [15:0] pc, input logic b, input string nm);
    bit exp_acc, hold_bad, overlap;
    int load_cnt, load_i, na_cnt, na_i, req_cyc;
    logic [15:0] load_pc, exp_pc;
    exp_acc = !b && (m_depth < MAXD);
    exp_pc = 16'(8*int'(v) + 3);
    load_cnt = 0; load_i = 0; na_cnt = 0; na_i = 0; req_cyc = 0; load_pc = '0;
    hold_bad = 0; overlap = 0;
    pushed.delete(); dlys.delete();
    wait_cm(nm);
    instr_end = 1'b1; vect = v; pc_in = pc; blk = b;
    @(negedge clk);
    instr_end = 1'b0; blk = 1'b0; vect = 3'($urandom_range(0, 7)); pc_in = 16'($urandom);
    for (int i = 1; i <= 30; i++) begin
      if (i > 1) @(negedge clk);
      if (pc_load) begin load_cnt++; load_i = i; load_pc = pc_out; end
      if (na) begin na_cnt++; na_i = i; end
      if (na && pc_load) overlap = 1;
      if (stk_req) req_cyc++;
      if (hold !== (exp_acc && (load_cnt == 0 || i == load_i))) hold_bad = 1;
    end
    n_tests++;
    if (hold_bad || overlap) begin
      n_fail++; $display("FAIL %s_hold: hold_bad=%0d na_load_overlap=%0d want 0/0", nm, hold_bad, overlap);
    end
    if (exp_acc) begin
      m_depth++;
      n_tests++;
      if (load_cnt != 1 || load_pc !== exp_pc) begin
        n_fail++; $display("FAIL %s_load: count=%0d pc=%h want 1 pc=%h", nm, load_cnt, load_pc, exp_pc);
      end
      n_tests++;
      if (pushed.size() != 2 || pushed[0] !== pc[7:0] || pushed[1] !== pc[15:8]) begin
        n_fail++; $display("FAIL %s_push: n=%0d want 2 bytes %h,%h", nm, pushed.size(), pc[7:0], pc[15:8]);
      end else begin
        n_tests++;
        if (load_i != 5 + dlys[0] + dlys[1]) begin
          n_fail++; $display("FAIL %s_latency: got %0d want %0d", nm, load_i, 5 + dlys[0] + dlys[1]);
        end
      end
      n_tests++;
      if (na_cnt != 0) begin n_fail++; $display("FAIL %s_na: got %0d pulses want 0", nm, na_cnt); end
    end else begin
      n_tests++;
      if (na_cnt != 1 || na_i != 1) begin
        n_fail++; $display("FAIL %s_na: got %0d pulses at %0d want 1 at 1", nm, na_cnt, na_i);
      end
      n_tests++;
      if (req_cyc != 0 || load_cnt != 0) begin
        n_fail++; $display("FAIL %s_noservice: req=%0d load=%0d want 0/0", nm, req_cyc, load_cnt);
      end
    end
    n_tests++;
    if (depth !== 2'(m_depth)) begin n_fail++; $display("FAIL %s_depth: got %0d want %0d", nm, depth, m_depth); end
  endtask

  task automatic do_reti(input string nm);
    bit exp_rdy;
    exp_rdy = (m_depth > 0);
    reti = 1'b1;
    @(negedge clk);
    reti = 1'b0;
    if (exp_rdy) m_depth--;
    n_tests++;
    if (rdy !== exp_rdy || depth !== 2'(m_depth)) begin
      n_fail++; $display("FAIL %s: rdy=%b depth=%0d want rdy=%b depth=%0d", nm, rdy, depth, exp_rdy, m_depth);
    end
    @(negedge clk);
    n_tests++;
    if (rdy !== 1'b0) begin n_fail++; $display("FAIL %s_pulse: rdy=%b want 0", nm, rdy); end
  endtask

  task automatic test_basic;
    service(3'd1, 16'h1234, 1'b0, "basic");
  endtask

  task automatic test_block;
    service(3'd2, 16'($urandom), 1'b1, "blk");
  endtask

  task automatic test_nesting;
    service(3'd5, 16'hBEEF, 1'b0, "nest2");
    service(3'd0, 16'h0F0F, 1'b0, "nest_full");
    do_reti("reti1");
    do_reti("reti2");
    do_reti("reti3");
  endtask

  task automatic test_off_cm;
    bit bad;
    bad = 0;
    wait_cm("offcm");
    @(negedge clk);
    instr_end = 1'b1; vect = 3'($urandom_range(0, 6)); pc_in = 16'($urandom);
    for (int k = 0; k < CPM-1; k++) begin
      @(negedge clk);
      if (stk_req || na || hold) bad = 1;
    end
    instr_end = 1'b0; vect = 3'd7;
    repeat (3) begin
      @(negedge clk);
      if (stk_req || na || hold) bad = 1;
    end
    n_tests++;
    if (bad) begin n_fail++; $display("FAIL off_cm: activity=1 want 0"); end
  endtask

  task automatic test_no_req;
    bit bad, ie;
    bad = 0;
    ie = 1'($urandom_range(0, 1));
    wait_cm("noreq");
    instr_end = ie; vect = ie ? 3'd7 : 3'($urandom_range(0, 6));
    @(negedge clk);
    instr_end = 1'b0; vect = 3'd7;
    repeat (4) begin
      if (stk_req || na || hold) bad = 1;
      @(negedge clk);
    end
    n_tests++;
    if (bad) begin n_fail++; $display("FAIL no_req(ie=%0d): activity=1 want 0", ie); end
  endtask

  task automatic test_reset_mid;
    bit found;
    logic [19:0] outs;
    found = 0;
    ack_budget = 1;
    wait_cm("rstmid");
    instr_end = 1'b1; vect = 3'd4; pc_in = 16'hA55A;
    @(negedge clk);
    instr_end = 1'b0; vect = 3'd7;
    for (int k = 0; k < 20 && !found; k++) begin
      if (stk_req && pushed.size() == 1) found = 1;
      else @(negedge clk);
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL rstmid_reach_push_h: found=0 want 1"); end
    #2 rst_n = 1'b0;
    #1;
    outs = {stk_req, pc_load, hold, na, rdy, depth, pc_out[12:0]};
    n_tests++;
    if (outs !== '0) begin n_fail++; $display("FAIL rstmid_async: got %h want 0", outs); end
    m_depth = 0;
    @(negedge clk);
    rst_n = 1'b1;
    ack_budget = -1;
    service(3'd6, 16'($urandom), 1'b0, "rstmid_after");
  endtask

  task automatic test_random;
    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: service(3'($urandom_range(0, 6)), 16'($urandom), ($urandom_range(0, 3) == 0), "rand_svc");
        3:       do_reti("rand_reti");
        4:       test_off_cm();
        default: test_no_req();
      endcase
    end
  endtask

  task automatic test_timeout;
`ifdef ISQ_ACK_TIMEOUT_EN
    int req_cyc, load_cnt;
    req_cyc = 0; load_cnt = 0;
    ack_en = 1'b0;
    wait_cm("tmo");
    instr_end = 1'b1; vect = 3'd3; pc_in = 16'h7788;
    @(negedge clk);
    instr_end = 1'b0; vect = 3'd7;
    for (int i = 1; i <= 80; i++) begin
      if (i > 1) @(negedge clk);
      if (stk_req) req_cyc++;
      if (pc_load) load_cnt++;
    end
    n_tests++;
    if (err !== 1'b1 || hold !== 1'b0 || load_cnt != 0 || req_cyc != TMO) begin
      n_fail++; $display("FAIL timeout: err=%b hold=%b loads=%0d req_cycles=%0d want 1 0 0 %0d",
                         err, hold, load_cnt, req_cyc, TMO);
    end
    n_tests++;
    if (depth !== 2'(m_depth)) begin n_fail++; $display("FAIL timeout_depth: got %0d want %0d", depth, m_depth); end
    ack_en = 1'b1;
    while (m_depth >= MAXD) do_reti("tmo_reti");
    service(3'd2, 16'($urandom), 1'b0, "tmo_after");
    n_tests++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: err=%b want 1", err); end
`else
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL err_tied: err=%b want 0", err); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_block();
    test_nesting();
    test_off_cm();
    test_no_req();
    test_reset_mid();
    test_random();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
